// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with sticky framing and overrun flags.
module uart_rx #(
    parameter int sys_clk    = 50000000,
    parameter int baud       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          Rst,
    input  logic                          RX,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          interrupt,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0]   BIT_CNT  = 32'(sys_clk / baud - 1);
    localparam logic [31:0]   HALF     = 32'(sys_clk / (2 * baud) - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          fe_set;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_CNT) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_CNT) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stop-bit sample outcome, decoded from registered state so the FIFO writes on the same edge.
    assign push   = (state == STOP) && (cnt == BIT_CNT) && rx_s;
    assign fe_set = (state == STOP) && (cnt == BIT_CNT) && !rx_s;

    assign full    = (rx_count == FULL_CNT);
    assign do_pop  = rd_en && (rx_count != '0);
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !rd_en;

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Set events win over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (Rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fe_set)       frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

    assign rd_data   = mem[rd_ptr];
    assign interrupt = (rx_count != '0);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: stimulus feeds a byte-level FIFO
// model (a queue), and a monitor checks every byte popped from the DUT.
module tb_uart_rx;

    localparam int DEPTH = 4;
    localparam int CPB   = 16;

    logic       clock = 1'b0;
    logic       Rst = 1'b1;
    logic       RX = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic [2:0] rx_count;
    logic       interrupt;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic       exp_fe = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [7:0] last_popped = 8'h00;

    uart_rx #(.sys_clk(16), .baud(1), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .Rst(Rst), .RX(RX), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_count(rx_count), .interrupt(interrupt),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample just before the rising edge, while everything is stable.
    task automatic settle();
        @(negedge clock);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clock);
        Rst = 1'b1;
        RX  = 1'b1;
        repeat (2) @(negedge clock);
        Rst = 1'b0;
        exp_q.delete();
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic pop();
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // One 8N1 frame at CPB cycles per bit. Cycle 154 is the one whose closing
    // edge samples the stop bit; pop_at_push raises rd_en for exactly that edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit pop_at_push);
        logic [9:0] fb;
        fb = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clock);
            RX = fb[c / CPB];
            if (c == 154) begin
                if (pop_at_push) rd_en = 1'b1;
                if (!stop_bit)                                    exp_fe = 1'b1;
                else if (exp_q.size() == DEPTH && !pop_at_push)   exp_ovr = 1'b1;
                else                                              exp_q.push_back(b);
            end else if (c == 155) begin
                rd_en = 1'b0;
            end
        end
        @(negedge clock);
        RX = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_state(input string tag);
        settle();
        check({tag, "_count"}, 32'(rx_count), 32'(exp_q.size()));
        check({tag, "_irq"}, 32'(interrupt), 32'(exp_q.size() != 0));
        check({tag, "_fe"}, 32'(frame_err), 32'(exp_fe));
        check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    // Monitor: every accepted pop must present the model's head byte.
    initial begin
        logic [7:0] e;
        forever begin
            settle();
            if (rd_en && interrupt) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", 32'(rd_data), 32'(e));
                    last_popped = rd_data;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [9:0] fb;
        bit         stop;

        do_reset();
        settle();
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        // Single good byte, then one pop.
        send_frame(8'h55, 1'b1, 1'b0);
        check_state("b55");
        check("b55_data", 32'(rd_data), 32'h55);
        pop();
        check_state("b55_pop");

        // Short low glitch on the line.
        @(negedge clock);
        RX = 1'b0;
        repeat (3) @(negedge clock);
        RX = 1'b1;
        repeat (3) @(negedge clock);
        check("glitch_busy_seen", 32'(busy), 32'd1);
        wait_idle(60);
        check_state("glitch");

        // Framing error and clear.
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        wait_idle(60);
        check_state("ferr");
        clear_err();
        check_state("ferr_clr");

        // Overrun: five bytes, no reads.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            repeat (4) @(negedge clock);
        end
        check_state("ovr");
        for (int i = 0; i < DEPTH; i++) pop();
        check_state("ovr_drain");
        check("ovr_last", 32'(last_popped), 32'h04);

        // Push and pop on the same edge while full.
        clear_err();
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
            repeat (4) @(negedge clock);
        end
        send_frame(8'h77, 1'b1, 1'b1);
        check_state("full_pp");
        for (int i = 0; i < DEPTH; i++) pop();
        check("full_pp_last", 32'(last_popped), 32'h77);
        check_state("full_pp_drain");

        // Reset in the middle of data bit 4.
        fb = {1'b1, 8'hC5, 1'b0};
        for (int c = 0; c < 88; c++) begin
            @(negedge clock);
            RX = fb[c / CPB];
        end
        settle();
        check("midrst_busy_pre", 32'(busy), 32'd1);
        do_reset();
        settle();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(rx_count), 32'd0);
        repeat (3) @(negedge clock);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_state("midrst_3c");
        check("midrst_data", 32'(rd_data), 32'h3C);
        pop();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, 1'b0);
            repeat ($urandom_range(5, 20)) @(negedge clock);
            wait_idle(60);
            check_state("rnd");
            repeat ($urandom_range(0, 2)) pop();
            if ($urandom_range(0, 3) == 0) clear_err();
        end
        for (int i = 0; i <= DEPTH && exp_q.size() > 0; i++) pop();
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter sys_clk, default 50000000, system clock frequency in Hz.
REQ-002 Parameter baud, default 9600, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, 2..16.
REQ-004 clock  input  1  system clock; all state SHALL update on its rising edge only.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 RX  input  1  asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-007 rd_en  input  1  pop request for the FIFO head.
REQ-008 err_clr  input  1  clears the sticky error flags.
REQ-009 rd_data  output  8  FIFO head byte, first-word-fall-through.
REQ-010 rx_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-011 interrupt  output  1  high while rx_count != 0.
REQ-012 frame_err  output  1  sticky flag: stop bit was sampled low.
REQ-013 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-014 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 The block SHALL define BIT_CNT = sys_clk/baud - 1 and HALF = sys_clk/(2*baud) - 1, using integer division.
REQ-016 RX SHALL pass through a two-flop synchronizer (both flops reset to 1); rx_s is the second flop's output and all decisions SHALL use rx_s.
REQ-017 The FSM states SHALL be IDLE, START, DATA and STOP, with a 32-bit cycle counter and a 3-bit bit index.
REQ-018 IDLE: when rx_s==0, the FSM SHALL go to START and clear the counter.
REQ-019 START: the counter SHALL increment each cycle; when counter==HALF and rx_s==0, the FSM SHALL go to DATA and clear the counter and bit index.
REQ-020 START: when counter==HALF and rx_s==1, the FSM SHALL treat the event as a glitch, return to IDLE and push nothing.
REQ-021 DATA: when counter==BIT_CNT, the block SHALL shift rx_s into the MSB of an 8-bit shift register (right shift), clear the counter and increment the bit index; after index 7 is sampled, the FSM SHALL go to STOP.
REQ-022 STOP: when counter==BIT_CNT and rx_s==1, the block SHALL push the shift register into the FIFO; the FSM SHALL return to IDLE in that same cycle.
REQ-023 STOP: when counter==BIT_CNT and rx_s==0, the block SHALL discard the byte and set frame_err; the FSM SHALL return to IDLE.
REQ-024 A push while the FIFO is full and rd_en is low SHALL drop the byte, leave the FIFO contents unchanged and set overrun.
REQ-025 A push and a pop in the same cycle while the FIFO is full SHALL both take effect: count unchanged, no overrun.
REQ-026 A push and a pop in the same cycle while the FIFO is empty SHALL be handled as a push only; the pop is ignored.
REQ-027 rd_en while the FIFO is empty SHALL be ignored; pointers and count SHALL not change.
REQ-028 rd_data SHALL equal the head entry combinationally while count>0; its value is don't-care while empty.
REQ-029 The read and write pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL never exceed FIFO_DEPTH.
REQ-030 err_clr SHALL clear frame_err and overrun on the next edge; a set event in the same cycle SHALL take priority (flag stays 1).
REQ-031 Latency: a pushed byte SHALL be visible on rd_data, with rx_count incremented, one cycle after the STOP mid-bit sample edge.
REQ-032 interrupt and busy SHALL be combinational decodes of registered state.

Reset
REQ-033 While Rst is high at a clock edge, the block SHALL set: FSM to IDLE; counter, bit index, shift register, pointers and rx_count to 0; frame_err and overrun to 0; synchronizer flops to 1.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no push and no flag set; the first falling edge after reset releases SHALL be treated as a new start bit.
REQ-035 After reset: interrupt=0, busy=0, rx_count=0.

Verification (sys_clk=16, baud=1, so BIT_CNT=15, HALF=7)
REQ-036 Drive 0x55 in 8N1 at 16 cycles/bit -> rx_count=1, rd_data=0x55, interrupt=1; rd_en for one cycle -> rx_count=0, interrupt=0.
REQ-037 Pulse RX low for 3 cycles, then hold high -> busy returns to 0, rx_count=0, no flag set.
REQ-038 Drive 0xA3 with the stop bit low -> frame_err=1, rx_count=0; pulse err_clr -> frame_err=0.
REQ-039 Drive 0x01,0x02,0x03,0x04,0x05 with no reads (FIFO_DEPTH=4) -> overrun=1, rx_count=4, pops return 0x01..0x04 in order.
REQ-040 With the FIFO full, assert rd_en in the push cycle of 0x77 -> overrun=0, rx_count=4, last entry popped is 0x77.
REQ-041 Assert Rst during DATA bit 4, then send 0x3C -> no partial byte stored, rx_count=1, rd_data=0x3C.
